// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer.
//
// Owns the fetch PC and drives the combinational instruction memory every cycle.
// Returned words and fault status are captured into a 2-entry FIFO that feeds
// decode over a valid/ready handshake. After a fetch exception the block stops
// fetching (HALT) until a redirect arrives. Reset is synchronous, active-high.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   - a fetch with fetch_pc[1:0] != 0 is pushed as an instruction-address-
//               misaligned exception (code 0, value = fetch_pc) and the FSM halts.
//   undefined - no check; memory is addressed word-aligned, out_pc keeps the raw PC.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   redirect_en_i/redirect_pc_i  branch/jump/trap redirect request and target
//   imem_addr_o                  fetch address (combinational from fetch PC)
//   imem_instr_i, imem_exc_*_i   same-cycle memory response and access-fault info
//   out_valid_o/out_ready_i      decode handshake for the FIFO head
//   out_pc_o, out_instr_o,
//   out_exc_en_o/code_o/val_o    FIFO head contents (zero while out_valid_o is low)
//   fetch_halted_o               high while the FSM is in HALT
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_en_i,
  input  logic [63:0] redirect_pc_i,
  output logic [63:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        imem_exc_en_i,
  input  logic [3:0]  imem_exc_code_i,
  input  logic [63:0] imem_exc_val_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] out_pc_o,
  output logic [31:0] out_instr_o,
  output logic        out_exc_en_o,
  output logic [3:0]  out_exc_code_o,
  output logic [63:0] out_exc_val_o,
  output logic        fetch_halted_o
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
  } entry_t;

  state_e      state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  entry_t      buf_q [2];
  entry_t      buf_d [2];

  entry_t      fetch_entry;
  entry_t      head;
  logic        pop;
  logic        push;
  logic        wr_idx;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign imem_addr_o = fetch_pc_q;
`else
  assign imem_addr_o = {fetch_pc_q[63:2], 2'b00};
`endif

  // Entry built from the current fetch; faults replace the word with a NOP.
  always_comb begin
    fetch_entry          = '0;
    fetch_entry.pc       = fetch_pc_q;
    fetch_entry.instr    = imem_instr_i;
`ifdef FETCH_MISALIGN_CHECK_EN
    if (fetch_pc_q[1:0] != 2'b00) begin
      fetch_entry.exc_en   = 1'b1;
      fetch_entry.exc_code = 4'd0;
      fetch_entry.exc_val  = fetch_pc_q;
      fetch_entry.instr    = Nop;
    end else
`endif
    if (imem_exc_en_i) begin
      fetch_entry.exc_en   = 1'b1;
      fetch_entry.exc_code = imem_exc_code_i;
      fetch_entry.exc_val  = imem_exc_val_i;
      fetch_entry.instr    = Nop;
    end
  end

  assign head        = buf_q[rd_ptr_q];
  assign out_valid_o = (count_q != 2'd0);
  assign pop         = out_valid_o & out_ready_i;
  assign push        = (state_q == StRun) & ~redirect_en_i & ((count_q != 2'd2) | pop);
  // Slot after the last valid entry; when full-and-popping this is the slot being freed.
  assign wr_idx      = rd_ptr_q ^ count_q[0];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    buf_d      = buf_q;

    if (redirect_en_i) begin
      // Flush wins over any same-cycle pop or push.
      count_d    = 2'd0;
      fetch_pc_d = redirect_pc_i;
      state_d    = StRun;
    end else begin
      if (push) begin
        buf_d[wr_idx] = fetch_entry;
        if (fetch_entry.exc_en) begin
          state_d = StHalt;
        end else begin
          fetch_pc_d = fetch_pc_q + 64'd4;
        end
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
    end
  end

  assign fetch_halted_o = (state_q == StHalt);

  // Data is forced to zero when no entry is presented.
  assign out_pc_o       = out_valid_o ? head.pc       : 64'd0;
  assign out_instr_o    = out_valid_o ? head.instr    : 32'd0;
  assign out_exc_en_o   = out_valid_o ? head.exc_en   : 1'b0;
  assign out_exc_code_o = out_valid_o ? head.exc_code : 4'd0;
  assign out_exc_val_o  = out_valid_o ? head.exc_val  : 64'd0;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam logic [63:0] ResetPc = 64'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc_en;
  logic [3:0]  out_exc_code;
  logic [63:0] out_exc_val;
  logic        fetch_halted;

  logic        exc_arm;
  logic [63:0] exc_addr;
  logic [3:0]  exc_code_drv;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(ResetPc)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .redirect_en_i  (redirect_en),
    .redirect_pc_i  (redirect_pc),
    .imem_addr_o    (imem_addr),
    .imem_instr_i   (imem_instr),
    .imem_exc_en_i  (imem_exc_en),
    .imem_exc_code_i(imem_exc_code),
    .imem_exc_val_i (imem_exc_val),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_pc_o       (out_pc),
    .out_instr_o    (out_instr),
    .out_exc_en_o   (out_exc_en),
    .out_exc_code_o (out_exc_code),
    .out_exc_val_o  (out_exc_val),
    .fetch_halted_o (fetch_halted)
  );

  // Instruction memory: word = 0x1 followed by the low 28 address bits.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {4'h1, a[27:0]};
  endfunction

  function automatic logic [63:0] mem_addr_of(input logic [63:0] pc);
`ifdef FETCH_MISALIGN_CHECK_EN
    return pc;
`else
    return {pc[63:2], 2'b00};
`endif
  endfunction

  assign imem_instr    = mem_word(imem_addr);
  assign imem_exc_en   = exc_arm && (imem_addr == exc_addr);
  assign imem_exc_code = exc_code_drv;
  assign imem_exc_val  = imem_addr;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  code;
    logic [63:0] val;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] mpc;
  bit          mhalt;
  bit          model_ok = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of delivered entries, fetch PC and halt flag.
  initial begin
    bit          do_pop;
    ent_t        e;
    logic [63:0] a;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        mpc      = ResetPc;
        mhalt    = 1'b0;
        model_ok = 1'b1;
      end else if (model_ok) begin
        if (redirect_en) begin
          mq.delete();
          mpc   = redirect_pc;
          mhalt = 1'b0;
        end else begin
          do_pop = (mq.size() > 0) && out_ready;
          if (do_pop) void'(mq.pop_front());
          if (!mhalt && (mq.size() < 2)) begin
            a        = mem_addr_of(mpc);
            e.pc     = mpc;
            e.instr  = mem_word(a);
            e.exc_en = 1'b0;
            e.code   = 4'd0;
            e.val    = 64'd0;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (mpc[1:0] != 2'b00) begin
              e.exc_en = 1'b1;
              e.val    = mpc;
            end else
`endif
            if (exc_arm && a == exc_addr) begin
              e.exc_en = 1'b1;
              e.code   = exc_code_drv;
              e.val    = a;
            end
            if (e.exc_en) e.instr = 32'h0000_0013;
            mq.push_back(e);
            if (e.exc_en) mhalt = 1'b1;
            else mpc = mpc + 64'd4;
          end
        end
      end
    end
  end

  // Every-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        check("imem_addr", imem_addr, mem_addr_of(mpc));
        check("fetch_halted", fetch_halted, mhalt);
        check("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
          check("out_pc", out_pc, mq[0].pc);
          check("out_instr", out_instr, mq[0].instr);
          check("out_exc", {out_exc_en, out_exc_code, out_exc_val},
                {mq[0].exc_en, mq[0].code, mq[0].val});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; redirect_en = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    exc_arm = 1'b0; exc_addr = '0; exc_code_drv = '0;

    // Reset state
    tick(1);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", {out_pc, out_instr, out_exc_en, out_exc_code, out_exc_val}, '0);
    check("rst_halted", fetch_halted, 1'b0);
    check("rst_addr", imem_addr, 64'h0);
    rst = 1'b0;

    // Streaming A, B, C one per cycle
    tick(1);
    check("s0_valid", out_valid, 1'b1);
    check("s0_pc", out_pc, 64'h0);
    check("s0_instr", out_instr, 32'h1000_0000);
    tick(1);
    check("s1_pc", out_pc, 64'h4);
    check("s1_instr", out_instr, 32'h1000_0004);
    tick(1);
    check("s2_pc", out_pc, 64'h8);
    check("s2_instr", out_instr, 32'h1000_0008);

    // Backpressure from a fresh reset
    rst = 1'b1;
    tick(1);
    rst = 1'b0; out_ready = 1'b0;
    tick(4);
    check("bp_pc", out_pc, 64'h0);
    check("bp_instr", out_instr, 32'h1000_0000);
    check("bp_addr", imem_addr, 64'h8);
    out_ready = 1'b1;
    tick(1);
    check("bp_r1", out_pc, 64'h4);
    tick(1);
    check("bp_r2", out_pc, 64'h8);
    tick(1);
    check("bp_r3", out_pc, 64'hc);

    // Memory fault at 0x2000
    redirect_en = 1'b1; redirect_pc = 64'h2000;
    exc_arm = 1'b1; exc_addr = 64'h2000; exc_code_drv = 4'd1;
    tick(1);
    redirect_en = 1'b0;
    check("fx_flush", out_valid, 1'b0);
    check("fx_addr", imem_addr, 64'h2000);
    tick(1);
    check("fx_pc", out_pc, 64'h2000);
    check("fx_instr", out_instr, 32'h0000_0013);
    check("fx_exc", {out_exc_en, out_exc_code, out_exc_val}, {1'b1, 4'd1, 64'h2000});
    check("fx_halt", fetch_halted, 1'b1);
    tick(3);
    check("fx_drained", out_valid, 1'b0);
    check("fx_halt_hold", fetch_halted, 1'b1);
    check("fx_addr_hold", imem_addr, 64'h2000);

    // Redirect out of HALT
    redirect_en = 1'b1; redirect_pc = 64'h40; exc_arm = 1'b0;
    tick(1);
    redirect_en = 1'b0;
    check("rd_halt", fetch_halted, 1'b0);
    check("rd_valid", out_valid, 1'b0);
    tick(1);
    check("rd_pc", out_pc, 64'h40);

    // Redirect coinciding with a pop of a full FIFO
    out_ready = 1'b0;
    tick(2);
    check("fp_addr", imem_addr, 64'h48);
    out_ready = 1'b1; redirect_en = 1'b1; redirect_pc = 64'h100;
    tick(1);
    redirect_en = 1'b0;
    check("fp_valid", out_valid, 1'b0);
    tick(1);
    check("fp_pc0", out_pc, 64'h100);
    tick(1);
    check("fp_pc1", out_pc, 64'h104);

    // Misaligned redirect target
    redirect_en = 1'b1; redirect_pc = 64'h42;
    tick(1);
    redirect_en = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("ma_addr", imem_addr, 64'h42);
    tick(1);
    check("ma_pc", out_pc, 64'h42);
    check("ma_instr", out_instr, 32'h0000_0013);
    check("ma_exc", {out_exc_en, out_exc_code, out_exc_val}, {1'b1, 4'd0, 64'h42});
    check("ma_halt", fetch_halted, 1'b1);
`else
    check("ma_addr", imem_addr, 64'h40);
    tick(1);
    check("ma_pc", out_pc, 64'h42);
    check("ma_instr", out_instr, 32'h1000_0040);
    check("ma_exc", out_exc_en, 1'b0);
    check("ma_addr1", imem_addr, 64'h44);
`endif

    // 64-bit PC wrap
    redirect_en = 1'b1; redirect_pc = 64'hffff_ffff_ffff_fffc;
    tick(1);
    redirect_en = 1'b0;
    tick(1);
    check("wr_pc", out_pc, 64'hffff_ffff_ffff_fffc);
    check("wr_addr", imem_addr, 64'h0);
    tick(1);
    check("wr_pc1", out_pc, 64'h0);

    // Reset overrides a same-cycle redirect
    rst = 1'b1; redirect_en = 1'b1; redirect_pc = 64'h500;
    tick(1);
    rst = 1'b0; redirect_en = 1'b0;
    check("rr_addr", imem_addr, ResetPc);
    check("rr_valid", out_valid, 1'b0);
    tick(1);
    check("rr_pc", out_pc, ResetPc);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
